// File: rtl/rect_bounce_multi.sv
// rect_bounce_multi: draws NRECT solid rectangles that bounce off the screen
// edges by SPEED pixels per frame. The pixel path is two registered stages:
// hit test, then priority colour select into the SDL outputs.
module rect_bounce_multi #(
  parameter int                  CORDW     = 10,
  parameter int                  H_RES     = 640,
  parameter int                  V_RES     = 480,
  parameter int                  NRECT     = 4,
  parameter int                  RECT_W    = 64,
  parameter int                  RECT_H    = 48,
  parameter int                  SPEED     = 2,
  parameter logic [12*NRECT-1:0] RECT_COLR = {NRECT{12'hFFF}},
  parameter logic [11:0]         BG_COLR   = 12'h137
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             frame,
  input  logic             pause,
  output logic [CORDW-1:0] sdl_sx,
  output logic [CORDW-1:0] sdl_sy,
  output logic             sdl_de,
  output logic [7:0]       sdl_r,
  output logic [7:0]       sdl_g,
  output logic [7:0]       sdl_b
);

  // One extra bit so that position + SPEED + size can never wrap.
  localparam int CW1 = CORDW + 1;
  localparam logic [CORDW:0] SPD  = CW1'(SPEED);
  localparam logic [CORDW:0] RW   = CW1'(RECT_W);
  localparam logic [CORDW:0] RH   = CW1'(RECT_H);
  localparam logic [CORDW:0] HRES = CW1'(H_RES);
  localparam logic [CORDW:0] VRES = CW1'(V_RES);

  // Parameter sanity: rectangles must fit side by side and move less than their size.
  if (NRECT < 1 || NRECT > 8) begin : g_chk_n
    $error("rect_bounce_multi: NRECT must be 1..8");
  end
  if (NRECT * RECT_W > H_RES) begin : g_chk_w
    $error("rect_bounce_multi: NRECT*RECT_W exceeds H_RES");
  end
  if (NRECT * RECT_H > V_RES) begin : g_chk_h
    $error("rect_bounce_multi: NRECT*RECT_H exceeds V_RES");
  end
  if (SPEED >= RECT_W || SPEED >= RECT_H) begin : g_chk_s
    $error("rect_bounce_multi: SPEED must be smaller than RECT_W and RECT_H");
  end

  logic [CORDW-1:0] pos_x [NRECT];
  logic [CORDW-1:0] pos_y [NRECT];
  logic [NRECT-1:0] dir_x;
  logic [NRECT-1:0] dir_y;

  logic [CORDW-1:0] nxt_x [NRECT];
  logic [CORDW-1:0] nxt_y [NRECT];
  logic [NRECT-1:0] nxt_dx;
  logic [NRECT-1:0] nxt_dy;

  logic [NRECT-1:0] hit;
  logic [NRECT-1:0] hit_q;
  logic             de_q;
  logic [CORDW-1:0] sx_q;
  logic [CORDW-1:0] sy_q;
  logic [11:0]      colr;

  // One axis of motion: returns {new_dir, new_pos}. A bounce clamps to the
  // edge and flips direction without moving further that frame.
  function automatic logic [CORDW:0] axis_step(
    input logic [CORDW-1:0] pos,
    input logic             dir,
    input logic [CORDW:0]   size,
    input logic [CORDW:0]   res
  );
    logic [CORDW:0]   p;
    logic [CORDW-1:0] np;
    logic             nd;
    p  = {1'b0, pos};
    np = pos;
    nd = dir;
    if (dir) begin
      if (p + SPD + size > res) begin
        np = CORDW'(res - size);
        nd = 1'b0;
      end else begin
        np = CORDW'(p + SPD);
      end
    end else begin
      if (p < SPD) begin
        np = '0;
        nd = 1'b1;
      end else begin
        np = CORDW'(p - SPD);
      end
    end
    return {nd, np};
  endfunction

  // Next position/direction of every rectangle, both axes independently.
  always_comb begin
    for (int i = 0; i < NRECT; i++) begin
      {nxt_dx[i], nxt_x[i]} = axis_step(pos_x[i], dir_x[i], RW, HRES);
      {nxt_dy[i], nxt_y[i]} = axis_step(pos_y[i], dir_y[i], RH, VRES);
    end
  end

  // Motion state: all rectangles step together on an unpaused frame pulse.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < NRECT; i++) begin
        pos_x[i] <= CORDW'(i * RECT_W);
        pos_y[i] <= CORDW'(i * RECT_H);
        dir_x[i] <= ((i % 2) == 0);
        dir_y[i] <= 1'b1;
      end
    end else if (frame && !pause) begin
      for (int i = 0; i < NRECT; i++) begin
        pos_x[i] <= nxt_x[i];
        pos_y[i] <= nxt_y[i];
        dir_x[i] <= nxt_dx[i];
        dir_y[i] <= nxt_dy[i];
      end
    end
  end

  // Hit test of the current pixel against the registered rectangle positions.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NRECT; i++) begin
      hit[i] = ({1'b0, sx} >= {1'b0, pos_x[i]}) &&
               ({1'b0, sx} <  {1'b0, pos_x[i]} + RW) &&
               ({1'b0, sy} >= {1'b0, pos_y[i]}) &&
               ({1'b0, sy} <  {1'b0, pos_y[i]} + RH);
    end
  end

  // Stage 1: capture the hit vector alongside the delayed pixel position.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hit_q <= '0;
      de_q  <= 1'b0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      hit_q <= hit;
      de_q  <= de;
      sx_q  <= sx;
      sy_q  <= sy;
    end
  end

  // Colour pick: lowest-index hit wins, background otherwise, black in blanking.
  always_comb begin
    colr = BG_COLR;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (hit_q[i]) colr = RECT_COLR[12*i +: 12];
    end
    if (!de_q) colr = '0;
  end

  // Stage 2: registered SDL outputs with 4-bit channels widened to 8 bits.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sdl_sx <= '0;
      sdl_sy <= '0;
      sdl_de <= 1'b0;
      sdl_r  <= '0;
      sdl_g  <= '0;
      sdl_b  <= '0;
    end else begin
      sdl_sx <= sx_q;
      sdl_sy <= sy_q;
      sdl_de <= de_q;
      sdl_r  <= {colr[11:8], colr[11:8]};
      sdl_g  <= {colr[7:4], colr[7:4]};
      sdl_b  <= {colr[3:0], colr[3:0]};
    end
  end

endmodule

// File: tb/tb_rect_bounce_multi.sv
// tb_rect_bounce_multi: randomized checks of rect_bounce_multi against a
// behavioural model of rectangle motion and pixel colouring.
module tb_rect_bounce_multi;

  localparam int CORDW  = 10;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int NRECT  = 4;
  localparam int RECT_W = 64;
  localparam int RECT_H = 48;
  localparam int SPEED  = 2;
  localparam logic [12*NRECT-1:0] COLR_PACKED = {12'hFF0, 12'h0F0, 12'h00F, 12'hF00};
  localparam logic [11:0] BG = 12'h137;

  typedef logic [1+2*CORDW+24-1:0] ent_t;

  logic             clk_pix = 1'b0;
  logic             rst_pix_n;
  logic [CORDW-1:0] sx, sy;
  logic             de, frame, pause;
  logic [CORDW-1:0] sdl_sx, sdl_sy;
  logic             sdl_de;
  logic [7:0]       sdl_r, sdl_g, sdl_b;

  logic [11:0] colr_tab [NRECT] = '{12'hF00, 12'h00F, 12'h0F0, 12'hFF0};
  int mx [NRECT];
  int my [NRECT];
  bit mdx [NRECT];
  bit mdy [NRECT];
  int total = 0;
  int bad   = 0;

  rect_bounce_multi #(
    .CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .NRECT(NRECT),
    .RECT_W(RECT_W), .RECT_H(RECT_H), .SPEED(SPEED),
    .RECT_COLR(COLR_PACKED), .BG_COLR(BG)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .sx(sx), .sy(sy), .de(de), .frame(frame), .pause(pause),
    .sdl_sx(sdl_sx), .sdl_sy(sdl_sy), .sdl_de(sdl_de),
    .sdl_r(sdl_r), .sdl_g(sdl_g), .sdl_b(sdl_b)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic void model_reset();
    for (int i = 0; i < NRECT; i++) begin
      mx[i] = i * RECT_W;
      my[i] = i * RECT_H;
      mdx[i] = (i % 2 == 0);
      mdy[i] = 1'b1;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < NRECT; i++) begin
      if (mdx[i]) begin
        if (mx[i] + SPEED + RECT_W > H_RES) begin mx[i] = H_RES - RECT_W; mdx[i] = 0; end
        else mx[i] += SPEED;
      end else begin
        if (mx[i] < SPEED) begin mx[i] = 0; mdx[i] = 1; end
        else mx[i] -= SPEED;
      end
      if (mdy[i]) begin
        if (my[i] + SPEED + RECT_H > V_RES) begin my[i] = V_RES - RECT_H; mdy[i] = 0; end
        else my[i] += SPEED;
      end else begin
        if (my[i] < SPEED) begin my[i] = 0; mdy[i] = 1; end
        else my[i] -= SPEED;
      end
    end
  endfunction

  function automatic logic [23:0] model_pix(int px, int py, bit d);
    logic [11:0] c;
    if (!d) return 24'h0;
    c = BG;
    for (int i = 0; i < NRECT; i++) begin
      if (px >= mx[i] && px < mx[i] + RECT_W && py >= my[i] && py < my[i] + RECT_H) begin
        c = colr_tab[i];
        break;
      end
    end
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  // Points on and just outside the edges of rectangle i.
  function automatic void edge_pt(input int i, input int k, output int px, output int py);
    case (k)
      0: begin px = mx[i];              py = my[i];              end
      1: begin px = mx[i] + RECT_W - 1; py = my[i] + RECT_H - 1; end
      2: begin px = mx[i] - 1;          py = my[i];              end
      3: begin px = mx[i] + RECT_W;     py = my[i] + RECT_H - 1; end
      4: begin px = mx[i];              py = my[i] - 1;          end
      default: begin px = mx[i] + RECT_W - 1; py = my[i] + RECT_H; end
    endcase
    if (px < 0) px = 0;
    if (py < 0) py = 0;
  endfunction

  task automatic present(input int px, input int py, input bit d);
    @(negedge clk_pix);
    sx = CORDW'(px);
    sy = CORDW'(py);
    de = d;
    @(posedge clk_pix);
    @(posedge clk_pix);
    #1;
  endtask

  task automatic do_frame(input bit p);
    @(negedge clk_pix);
    frame = 1'b1;
    pause = p;
    @(posedge clk_pix);
    #1;
    frame = 1'b0;
    pause = 1'b0;
    if (!p) model_step();
  endtask

  task automatic test_reset();
    logic [23:0] exp;
    rst_pix_n = 1'b0;
    sx = 10'd5; sy = 10'd5; de = 1'b1; frame = 1'b0; pause = 1'b0;
    repeat (3) begin
      @(negedge clk_pix);
      frame = 1'b1;
      @(posedge clk_pix);
      #1;
      total++;
      if ({sdl_r, sdl_g, sdl_b, sdl_sx, sdl_sy, sdl_de} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_hold: got %h/%h/%h de=%b expected all zero", sdl_r, sdl_g, sdl_b, sdl_de);
      end
    end
    @(negedge clk_pix);
    frame = 1'b0;
    rst_pix_n = 1'b1;
    model_reset();
    exp = model_pix(5, 5, 1'b1);
    @(posedge clk_pix);
    #1;
    total++;
    if (sdl_de !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release_early: sdl_de got %b expected 0", sdl_de);
    end
    @(posedge clk_pix);
    #1;
    total++;
    if ({sdl_r, sdl_g, sdl_b} !== exp) begin
      bad++;
      $display("[TB] FAIL reset_release_pix: got %h expected %h", {sdl_r, sdl_g, sdl_b}, exp);
    end
    total++;
    if (sdl_sx !== 10'd5 || sdl_de !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_pos: sx=%0d de=%b expected sx=5 de=1", sdl_sx, sdl_de);
    end
  endtask

  task automatic test_latency();
    logic [23:0] exp;
    exp = model_pix(300, 300, 1'b1);
    @(negedge clk_pix);
    sx = 10'd300; sy = 10'd300; de = 1'b1;
    @(posedge clk_pix);
    #1;
    total++;
    if (sdl_sx !== 10'd5) begin
      bad++;
      $display("[TB] FAIL latency_early: sdl_sx got %0d expected 5", sdl_sx);
    end
    @(posedge clk_pix);
    #1;
    total++;
    if ({sdl_r, sdl_g, sdl_b} !== exp || sdl_sx !== 10'd300 || sdl_sy !== 10'd300) begin
      bad++;
      $display("[TB] FAIL latency_pix: got %h at (%0d,%0d) expected %h at (300,300)",
               {sdl_r, sdl_g, sdl_b}, sdl_sx, sdl_sy, exp);
    end
    present(300, 300, 1'b0);
    total++;
    if ({sdl_r, sdl_g, sdl_b} !== 24'h0 || sdl_de !== 1'b0 || sdl_sx !== 10'd300) begin
      bad++;
      $display("[TB] FAIL blanking: got %h de=%b sx=%0d expected 000000 de=0 sx=300",
               {sdl_r, sdl_g, sdl_b}, sdl_de, sdl_sx);
    end
  endtask

  task automatic test_pause();
    int px, py;
    logic [23:0] exp;
    do_frame(1'b0);
    do_frame(1'b0);
    repeat (3) do_frame(1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NRECT; i++) begin
        for (int k = 0; k < 6; k++) begin
          edge_pt(i, k, px, py);
          exp = model_pix(px, py, 1'b1);
          present(px, py, 1'b1);
          total++;
          if ({sdl_r, sdl_g, sdl_b} !== exp) begin
            bad++;
            $display("[TB] FAIL pause_pass%0d rect%0d pt%0d (%0d,%0d): got %h expected %h",
                     pass, i, k, px, py, {sdl_r, sdl_g, sdl_b}, exp);
          end
        end
      end
      if (pass == 0) do_frame(1'b0);
    end
  endtask

  task automatic test_bounce();
    int px, py, n;
    logic [23:0] exp;
    n = 0;
    while (!(mx[0] == H_RES - RECT_W - SPEED && mdx[0]) && n < 1200) begin
      do_frame(1'b0);
      n++;
    end
    total++;
    if (n >= 1200) begin
      bad++;
      $display("[TB] FAIL bounce_setup: x0 never reached %0d", H_RES - RECT_W - SPEED);
    end
    repeat (3) begin
      do_frame(1'b0);
      for (int k = 0; k < 4; k++) begin
        edge_pt(0, k, px, py);
        exp = model_pix(px, py, 1'b1);
        present(px, py, 1'b1);
        total++;
        if ({sdl_r, sdl_g, sdl_b} !== exp) begin
          bad++;
          $display("[TB] FAIL bounce_right pt%0d (%0d,%0d): got %h expected %h",
                   k, px, py, {sdl_r, sdl_g, sdl_b}, exp);
        end
      end
    end
    n = 0;
    while (!(mx[1] < SPEED && !mdx[1]) && n < 1200) begin
      do_frame(1'b0);
      n++;
    end
    do_frame(1'b0);
    for (int k = 0; k < 4; k++) begin
      edge_pt(1, k, px, py);
      exp = model_pix(px, py, 1'b1);
      present(px, py, 1'b1);
      total++;
      if ({sdl_r, sdl_g, sdl_b} !== exp) begin
        bad++;
        $display("[TB] FAIL bounce_left pt%0d (%0d,%0d): got %h expected %h",
                 k, px, py, {sdl_r, sdl_g, sdl_b}, exp);
      end
    end
  endtask

  task automatic test_overlap();
    int px, py, found, n;
    logic [23:0] exp;
    found = 0;
    n = 0;
    while (found < 3 && n < 3000) begin
      do_frame(1'b0);
      n++;
      for (int i = 0; i < NRECT; i++) begin
        for (int j = i + 1; j < NRECT; j++) begin
          px = (mx[i] > mx[j]) ? mx[i] : mx[j];
          py = (my[i] > my[j]) ? my[i] : my[j];
          if (found < 3 && px < mx[i] + RECT_W && px < mx[j] + RECT_W &&
              py < my[i] + RECT_H && py < my[j] + RECT_H) begin
            exp = model_pix(px, py, 1'b1);
            present(px, py, 1'b1);
            total++;
            if ({sdl_r, sdl_g, sdl_b} !== exp) begin
              bad++;
              $display("[TB] FAIL overlap rect%0d/rect%0d (%0d,%0d): got %h expected %h",
                       i, j, px, py, {sdl_r, sdl_g, sdl_b}, exp);
            end
            found++;
          end
        end
      end
    end
    if (found == 0) $display("[TB] note: no overlapping rectangles seen");
  endtask

  task automatic test_back_to_back();
    ent_t q[$];
    ent_t e;
    int px, py;
    bit d, f, p;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_pix);
      if (q.size() >= 2) begin
        e = q.pop_front();
        total++;
        if ({sdl_de, sdl_sx, sdl_sy, sdl_r, sdl_g, sdl_b} !== e) begin
          bad++;
          $display("[TB] FAIL stream cycle %0d: got %h expected %h", c,
                   {sdl_de, sdl_sx, sdl_sy, sdl_r, sdl_g, sdl_b}, e);
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        edge_pt(int'($urandom_range(0, NRECT - 1)), int'($urandom_range(0, 5)), px, py);
      end else begin
        px = int'($urandom_range(0, 700));
        py = int'($urandom_range(0, 520));
      end
      d = ($urandom_range(0, 4) != 0);
      f = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 3) == 0);
      sx = CORDW'(px);
      sy = CORDW'(py);
      de = d;
      frame = f;
      pause = p;
      q.push_back({d, CORDW'(px), CORDW'(py), model_pix(px, py, d)});
      if (f && !p) model_step();
    end
    @(negedge clk_pix);
    frame = 1'b0;
    pause = 1'b0;
  endtask

  task automatic test_mid_reset();
    int px, py;
    logic [23:0] exp;
    repeat (5) do_frame(1'b0);
    px = mx[2] + 3;
    py = my[2] + 3;
    exp = model_pix(px, py, 1'b1);
    present(px, py, 1'b1);
    total++;
    if ({sdl_r, sdl_g, sdl_b} !== exp) begin
      bad++;
      $display("[TB] FAIL midreset_before: got %h expected %h", {sdl_r, sdl_g, sdl_b}, exp);
    end
    #1;
    rst_pix_n = 1'b0;
    #1;
    total++;
    if ({sdl_r, sdl_g, sdl_b, sdl_sx, sdl_sy, sdl_de} !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_async: got %h/%h/%h de=%b expected all zero", sdl_r, sdl_g, sdl_b, sdl_de);
    end
    @(posedge clk_pix);
    #2;
    rst_pix_n = 1'b1;
    model_reset();
    sx = 10'd5;
    sy = 10'd5;
    exp = model_pix(5, 5, 1'b1);
    @(posedge clk_pix);
    #1;
    total++;
    if (sdl_de !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_early: sdl_de got %b expected 0", sdl_de);
    end
    @(posedge clk_pix);
    #1;
    total++;
    if ({sdl_r, sdl_g, sdl_b} !== exp || sdl_de !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_resume: got %h de=%b expected %h de=1", {sdl_r, sdl_g, sdl_b}, sdl_de, exp);
    end
    for (int i = 0; i < NRECT; i++) begin
      px = mx[i] + RECT_W - 1;
      py = my[i];
      exp = model_pix(px, py, 1'b1);
      present(px, py, 1'b1);
      total++;
      if ({sdl_r, sdl_g, sdl_b} !== exp) begin
        bad++;
        $display("[TB] FAIL midreset_pos rect%0d: got %h expected %h", i, {sdl_r, sdl_g, sdl_b}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_pause();
    test_bounce();
    test_overlap();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
